// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan monitor: glyph patterns, blank code, FSM states.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [4:0] CODE_BLANK = 5'h10;

    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_e;

    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] one_hot_idx4(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-high 7-bit segment pattern -> {ok, hex/blank code}.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [4:0] code
);

    // Map each recognised glyph to its code; anything else is flagged not ok.
    always_comb begin
        ok   = 1'b1;
        code = CODE_BLANK;
        case (pattern)
            GLYPH_BLANK: code = CODE_BLANK;
            GLYPH_0:     code = 5'h00;
            GLYPH_1:     code = 5'h01;
            GLYPH_2:     code = 5'h02;
            GLYPH_3:     code = 5'h03;
            GLYPH_4:     code = 5'h04;
            GLYPH_5:     code = 5'h05;
            GLYPH_6:     code = 5'h06;
            GLYPH_7:     code = 5'h07;
            GLYPH_8:     code = 5'h08;
            GLYPH_9:     code = 5'h09;
            GLYPH_A:     code = 5'h0A;
            GLYPH_B:     code = 5'h0B;
            GLYPH_C:     code = 5'h0C;
            GLYPH_D:     code = 5'h0D;
            GLYPH_E:     code = 5'h0E;
            GLYPH_F:     code = 5'h0F;
            default: begin
                ok   = 1'b0;
                code = CODE_BLANK;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Receiver for a multiplexed 4-digit 7-segment bus: recovers each digit's character.
// Optional decimal-point capture is enabled by defining SEG7_DP_CAPTURE_EN.
module seg7_scan_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock_entrada,
    input  logic        reset,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_n,
    output logic [19:0] digit_code,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp_out,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        pat_err,
    output logic        multi_err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    // Idle bus value (all digits off, all segments dark) so reset does not look like activity.
    localparam logic [11:0] IDLE_BUS = {4'hF, (SEG_ACTIVE_LOW ? 8'hFF : 8'h00)};

    logic [11:0]        sync1_r, samp_r, prev_r;
    state_e             state_r;
    logic [CW-1:0]      cnt_r;
    logic               upd_r, multi_err_r, pat_err_r;
    logic [1:0]         upd_idx_r;
    logic [3:0][4:0]    code_r;
    logic [3:0]         valid_r;
    logic [3:0][TW-1:0] tmo_r;

    logic       same_s, any_en_s, one_s, act_s, wr_s, dec_ok_s;
    logic [3:0] en_s;
    logic [1:0] slot_s;
    logic [6:0] seg_norm_s;
    logic [4:0] dec_code_s;

    // Sample classification and capture decision.
    always_comb begin
        same_s     = (samp_r == prev_r);
        en_s       = ~samp_r[11:8];
        any_en_s   = |en_s;
        one_s      = is_one_hot4(en_s);
        slot_s     = one_hot_idx4(en_s);
        seg_norm_s = SEG_ACTIVE_LOW ? ~samp_r[6:0] : samp_r[6:0];
        act_s      = (state_r == SETTLE) && same_s && (cnt_r == CNT_MAX);
        wr_s       = act_s && one_s;
    end

    seg7_glyph_decode u_decode (
        .pattern (seg_norm_s),
        .ok      (dec_ok_s),
        .code    (dec_code_s)
    );

    // Two-stage synchronizer plus one-sample history for change detection.
    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            sync1_r <= IDLE_BUS;
            samp_r  <= IDLE_BUS;
            prev_r  <= IDLE_BUS;
        end else begin
            sync1_r <= {dig_n, seg_in};
            samp_r  <= sync1_r;
            prev_r  <= samp_r;
        end
    end

    // Stability counter, scan FSM, update strobe and multi-digit error.
    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            state_r     <= WAIT;
            cnt_r       <= '0;
            upd_r       <= 1'b0;
            upd_idx_r   <= 2'd0;
            multi_err_r <= 1'b0;
        end else begin
            upd_r <= wr_s;
            if (wr_s) begin
                upd_idx_r <= slot_s;
            end
            if (act_s && any_en_s && !one_s) begin
                multi_err_r <= 1'b1;
            end
            if (!same_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 1'b1;
            end
            case (state_r)
                WAIT: begin
                    if (any_en_s) begin
                        state_r <= SETTLE;
                        cnt_r   <= '0;
                    end
                end
                SETTLE: begin
                    if (act_s) begin
                        state_r <= HELD;
                    end
                end
                HELD: begin
                    if (!same_s) begin
                        state_r <= any_en_s ? SETTLE : WAIT;
                        cnt_r   <= '0;
                    end
                end
                default: state_r <= WAIT;
            endcase
        end
    end

    // Slot registers: a write beats a coinciding timeout on the same slot.
    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            code_r    <= {4{CODE_BLANK}};
            valid_r   <= 4'b0000;
            pat_err_r <= 1'b0;
        end else begin
            if (wr_s && !dec_ok_s) begin
                pat_err_r <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_s && (slot_s == 2'(i))) begin
                    code_r[i]  <= dec_ok_s ? dec_code_s : CODE_BLANK;
                    valid_r[i] <= dec_ok_s;
                end else if (tmo_r[i] == TMO_LAST) begin
                    valid_r[i] <= 1'b0;
                end
            end
        end
    end

    // Per-slot refresh timers, saturating at the timeout value.
    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            tmo_r <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_s && (slot_s == 2'(i))) begin
                    tmo_r[i] <= '0;
                end else if (tmo_r[i] != TMO_MAX) begin
                    tmo_r[i] <= tmo_r[i] + 1'b1;
                end
            end
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0] dp_r;
    logic       dp_norm_s;

    assign dp_norm_s = SEG_ACTIVE_LOW ? ~samp_r[7] : samp_r[7];

    // Decimal point captured alongside each slot write.
    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            dp_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_s && (slot_s == 2'(i))) begin
                    dp_r[i] <= dp_norm_s;
                end
            end
        end
    end

    assign dp_out = dp_r;
`else
    assign dp_out = 4'b0000;
`endif

    assign digit_code  = code_r;
    assign digit_valid = valid_r;
    assign upd         = upd_r;
    assign upd_idx     = upd_idx_r;
    assign pat_err     = pat_err_r;
    assign multi_err   = multi_err_r;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Directed self-checking bench for seg7_scan_monitor (STABLE=4, TIMEOUT=64, active-low segments).
module tb_seg7_scan_monitor;

    localparam logic [19:0] CODES_RST = 20'h84210;
    localparam logic [7:0]  SEG_IDLE  = 8'hFF;
    localparam logic [3:0]  DIG_OFF   = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_n;
    logic [19:0] digit_code;
    logic [3:0]  digit_valid;
    logic [3:0]  dp_out;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        pat_err;
    logic        multi_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int wr2_cyc = 0;
    logic [1:0] last_idx = 2'd0;
    int base;
    logic [3:0] dp_exp;
    bit found;

    seg7_scan_monitor #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock_entrada (clk),
        .reset         (rst),
        .seg_in        (seg_in),
        .dig_n         (dig_n),
        .digit_code    (digit_code),
        .digit_valid   (digit_valid),
        .dp_out        (dp_out),
        .upd           (upd),
        .upd_idx       (upd_idx),
        .pat_err       (pat_err),
        .multi_err     (multi_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (upd) begin
            upd_cnt  <= upd_cnt + 1;
            last_idx <= upd_idx;
            if (upd_idx == 2'd2) wr2_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
        seg_in = s;
        dig_n  = d;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"}, 32'(digit_code), 32'(CODES_RST));
        chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
        chk({tag, "_dp"}, 32'(dp_out), 32'h0);
        chk({tag, "_upd"}, 32'(upd), 32'h0);
        chk({tag, "_idx"}, 32'(upd_idx), 32'h0);
        chk({tag, "_perr"}, 32'(pat_err), 32'h0);
        chk({tag, "_merr"}, 32'(multi_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        seg_in = SEG_IDLE;
        dig_n = DIG_OFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("rst");

        // Single stable "3" on d1
        base = upd_cnt;
        hold(8'hB0, 4'b1110, 10);
        chk("d3_upd_count", 32'(upd_cnt - base), 32'd1);
        chk("d3_idx", 32'(last_idx), 32'd0);
        chk("d3_code", 32'(digit_code[4:0]), 32'h03);
        chk("d3_valid", 32'(digit_valid), 32'h1);
        hold(SEG_IDLE, DIG_OFF, 5);

        // Reset while a capture of "1" on d2 is pending
        hold(8'hF9, 4'b1101, 4);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        seg_in = SEG_IDLE;
        dig_n = DIG_OFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = upd_cnt;
        hold(SEG_IDLE, DIG_OFF, 15);
        chk("midrst_no_upd", 32'(upd_cnt - base), 32'd0);
        chk("midrst_valid", 32'(digit_valid), 32'h0);

        // Scan "1","2","A",blank across d1..d4
        base = upd_cnt;
        hold(8'hF9, 4'b1110, 12);
        hold(SEG_IDLE, DIG_OFF, 3);
        hold(8'hA4, 4'b1101, 12);
        hold(SEG_IDLE, DIG_OFF, 3);
        hold(8'h88, 4'b1011, 12);
        hold(SEG_IDLE, DIG_OFF, 3);
        hold(SEG_IDLE, 4'b0111, 12);
        chk("scan_upd_count", 32'(upd_cnt - base), 32'd4);
        chk("scan_last_idx", 32'(last_idx), 32'd3);
        chk("scan_codes", 32'(digit_code), 32'h82841);
        chk("scan_valid", 32'(digit_valid), 32'hF);
        chk("scan_dp", 32'(dp_out), 32'h0);
        chk("scan_perr", 32'(pat_err), 32'h0);
        hold(SEG_IDLE, DIG_OFF, 5);

        // Two digits enabled at once
        base = upd_cnt;
        hold(8'hB0, 4'b1100, 10);
        chk("multi_err", 32'(multi_err), 32'h1);
        chk("multi_no_upd", 32'(upd_cnt - base), 32'd0);
        hold(SEG_IDLE, DIG_OFF, 5);

        // Undecodable pattern on d1
        base = upd_cnt;
        hold(8'hAA, 4'b1110, 10);
        chk("pat_err", 32'(pat_err), 32'h1);
        chk("pat_upd", 32'(upd_cnt - base), 32'd1);
        chk("pat_code", 32'(digit_code[4:0]), 32'h10);
        chk("pat_valid0", 32'(digit_valid[0]), 32'h0);
        chk("pat_merr_sticky", 32'(multi_err), 32'h1);
        hold(SEG_IDLE, DIG_OFF, 5);

        // Ghosting on d2: segments toggle every 3 cycles
        base = upd_cnt;
        for (int k = 0; k < 5; k++) begin
            hold(8'hB0, 4'b1101, 3);
            hold(8'hF9, 4'b1101, 3);
        end
        chk("ghost_no_upd", 32'(upd_cnt - base), 32'd0);
        hold(8'hF9, 4'b1101, 10);
        chk("ghost_then_upd", 32'(upd_cnt - base), 32'd1);
        chk("ghost_code", 32'(digit_code[9:5]), 32'h01);
        hold(SEG_IDLE, DIG_OFF, 5);

        // Refresh d3 once, then let it time out
        base = upd_cnt;
        hold(8'hB0, 4'b1011, 10);
        chk("tmo_upd", 32'(upd_cnt - base), 32'd1);
        chk("tmo_idx", 32'(last_idx), 32'd2);
        seg_in = SEG_IDLE;
        dig_n = DIG_OFF;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #1;
            if (cyc == wr2_cyc + 63) found = 1'b1;
        end
        chk("tmo_wait", 32'(found), 32'h1);
        chk("tmo_valid_63", 32'(digit_valid[2]), 32'h1);
        @(negedge clk);
        #1;
        chk("tmo_valid_64", 32'(digit_valid[2]), 32'h0);
        chk("tmo_code_kept", 32'(digit_code[14:10]), 32'h03);

        // All segments plus decimal point lit on d1
`ifdef SEG7_DP_CAPTURE_EN
        dp_exp = 4'b0001;
`else
        dp_exp = 4'b0000;
`endif
        hold(8'h00, 4'b1110, 10);
        chk("dp_code8", 32'(digit_code[4:0]), 32'h08);
        chk("dp_valid0", 32'(digit_valid[0]), 32'h1);
        chk("dp_out", 32'(dp_out), 32'(dp_exp));
        hold(SEG_IDLE, DIG_OFF, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
